// File: rtl/rv32_bus_arbiter.sv
// Two-master (instruction fetch / data load-store) to one-slave bus arbiter.
// The granted request is registered onto the shared bus; ready returns only to its owner.
module rv32_bus_arbiter #(
    parameter bit PRIORITY_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [3:0]  mem_write_mask_out,
    output logic [31:0] mem_write_value_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in
);

    typedef enum logic [1:0] {IDLE, INSTR, DATA, DRAIN} state_t;

    state_t state;
    logic   last_grant_data;
    logic   data_req;
    logic   grant_data;
    logic   grant_instr;
    logic   owner_req;

    // On a tie, round-robin hands the bus to whichever master did not have it last.
    always_comb begin
        data_req    = data_read_in | data_write_in;
        grant_data  = data_req & (~instr_read_in | PRIORITY_DATA | ~last_grant_data);
        grant_instr = instr_read_in & ~grant_data;
        owner_req   = (state == INSTR) ? instr_read_in : data_req;
    end

    assign instr_read_value_out = mem_read_value_in;
    assign data_read_value_out  = mem_read_value_in;
    assign instr_ready_out      = (state == INSTR) & mem_ready_in & instr_read_in;
    assign data_ready_out       = (state == DATA) & mem_ready_in & data_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            last_grant_data     <= 1'b1;
            mem_address_out     <= '0;
            mem_read_out        <= 1'b0;
            mem_write_out       <= 1'b0;
            mem_write_mask_out  <= '0;
            mem_write_value_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state               <= DATA;
                        last_grant_data     <= 1'b1;
                        mem_address_out     <= data_address_in;
                        // Read+write together is illegal; the store wins.
                        mem_read_out        <= data_read_in & ~data_write_in;
                        mem_write_out       <= data_write_in;
                        mem_write_mask_out  <= data_write_mask_in;
                        mem_write_value_out <= data_write_value_in;
                    end else if (grant_instr) begin
                        state               <= INSTR;
                        last_grant_data     <= 1'b0;
                        mem_address_out     <= instr_address_in;
                        mem_read_out        <= 1'b1;
                        mem_write_out       <= 1'b0;
                        mem_write_mask_out  <= '0;
                        mem_write_value_out <= '0;
                    end
                end
                INSTR, DATA: begin
                    if (mem_ready_in) begin
                        state               <= IDLE;
                        mem_address_out     <= '0;
                        mem_read_out        <= 1'b0;
                        mem_write_out       <= 1'b0;
                        mem_write_mask_out  <= '0;
                        mem_write_value_out <= '0;
                    end else if (!owner_req) begin
                        // Master flushed: keep the bus until the slave finishes.
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ready_in) begin
                        state               <= IDLE;
                        mem_address_out     <= '0;
                        mem_read_out        <= 1'b0;
                        mem_write_out       <= 1'b0;
                        mem_write_mask_out  <= '0;
                        mem_write_value_out <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed, table-driven bench for rv32_bus_arbiter: fixed-priority instance for the
// main vectors, flush and reset sequences; round-robin instance for tie alternation.
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address_in;
    logic        instr_read_in;
    logic [31:0] data_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] mem_read_value_in;
    logic        mem_ready_in;

    logic [31:0] p_irv, p_drv, p_addr, p_val;
    logic        p_ir, p_dr, p_mrd, p_mwr;
    logic [3:0]  p_mask;
    logic [31:0] r_irv, r_drv, r_addr, r_val;
    logic        r_ir, r_dr, r_mrd, r_mwr;
    logic [3:0]  r_mask;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rv32_bus_arbiter #(.PRIORITY_DATA(1'b1)) dut (
        .clk(clk), .reset(reset),
        .instr_address_in(instr_address_in), .instr_read_in(instr_read_in),
        .instr_read_value_out(p_irv), .instr_ready_out(p_ir),
        .data_address_in(data_address_in), .data_read_in(data_read_in),
        .data_write_in(data_write_in), .data_write_mask_in(data_write_mask_in),
        .data_write_value_in(data_write_value_in),
        .data_read_value_out(p_drv), .data_ready_out(p_dr),
        .mem_address_out(p_addr), .mem_read_out(p_mrd), .mem_write_out(p_mwr),
        .mem_write_mask_out(p_mask), .mem_write_value_out(p_val),
        .mem_read_value_in(mem_read_value_in), .mem_ready_in(mem_ready_in)
    );

    rv32_bus_arbiter #(.PRIORITY_DATA(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .instr_address_in(instr_address_in), .instr_read_in(instr_read_in),
        .instr_read_value_out(r_irv), .instr_ready_out(r_ir),
        .data_address_in(data_address_in), .data_read_in(data_read_in),
        .data_write_in(data_write_in), .data_write_mask_in(data_write_mask_in),
        .data_write_value_in(data_write_value_in),
        .data_read_value_out(r_drv), .data_ready_out(r_dr),
        .mem_address_out(r_addr), .mem_read_out(r_mrd), .mem_write_out(r_mwr),
        .mem_write_mask_out(r_mask), .mem_write_value_out(r_val),
        .mem_read_value_in(mem_read_value_in), .mem_ready_in(mem_ready_in)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  dm;
        logic [31:0] dv;
        logic [31:0] da;
        logic        mr;
        logic [31:0] mv;
        logic        xi;    // expected instr_ready_out this cycle
        logic        xd;    // expected data_ready_out this cycle
        logic        xmr;   // expected bus state after the edge
        logic        xmw;
        logic [31:0] xa;
        logic [3:0]  xm;
        logic [31:0] xv;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [3:0] dm, input logic [31:0] dv, input logic [31:0] da,
        input logic mr, input logic [31:0] mv, input logic xi, input logic xd,
        input logic xmr, input logic xmw, input logic [31:0] xa,
        input logic [3:0] xm, input logic [31:0] xv);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dm = dm; v.dv = dv; v.da = da;
        v.mr = mr; v.mv = mv; v.xi = xi; v.xd = xd;
        v.xmr = xmr; v.xmw = xmw; v.xa = xa; v.xm = xm; v.xv = xv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs, check combinational readies, then the registered bus.
    task automatic step(input vec_t v, input bit rr, input string tag);
        instr_read_in       = v.ir;
        instr_address_in    = v.ia;
        data_read_in        = v.dr;
        data_write_in       = v.dw;
        data_write_mask_in  = v.dm;
        data_write_value_in = v.dv;
        data_address_in     = v.da;
        mem_ready_in        = v.mr;
        mem_read_value_in   = v.mv;
        #2;
        chk({tag, " instr_ready"}, rr ? r_ir : p_ir, v.xi);
        chk({tag, " data_ready"},  rr ? r_dr : p_dr, v.xd);
        if (v.mr) begin
            chk({tag, " instr_rdata"}, rr ? r_irv : p_irv, v.mv);
            chk({tag, " data_rdata"},  rr ? r_drv : p_drv, v.mv);
        end
        @(posedge clk);
        #1;
        chk({tag, " mem_read"},  rr ? r_mrd  : p_mrd,  v.xmr);
        chk({tag, " mem_write"}, rr ? r_mwr  : p_mwr,  v.xmw);
        chk({tag, " mem_addr"},  rr ? r_addr : p_addr, v.xa);
        chk({tag, " mem_mask"},  rr ? r_mask : p_mask, v.xm);
        chk({tag, " mem_value"}, rr ? r_val  : p_val,  v.xv);
    endtask

    task automatic chk_bus_zero(input string tag);
        chk({tag, " p_read"},  p_mrd,  0);
        chk({tag, " p_write"}, p_mwr,  0);
        chk({tag, " p_addr"},  p_addr, 0);
        chk({tag, " p_mask"},  p_mask, 0);
        chk({tag, " p_value"}, p_val,  0);
        chk({tag, " r_read"},  r_mrd,  0);
        chk({tag, " r_addr"},  r_addr, 0);
    endtask

    vec_t vecs[19];
    vec_t seq[$];

    initial begin
        // ir  ia     dr dw dm    dv            da        mr mv     xi xd xmr xmw xa       xm    xv
        vecs[0]  = mk(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0,    0, 32'h0,  0, 0, 1, 0, 32'h100,  4'h0, 32'h0);
        vecs[1]  = mk(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0,    1, 32'h13, 1, 0, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[2]  = mk(0, 32'h0,   0, 0, 4'h0, 32'h0, 32'h0,    0, 32'h0,  0, 0, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[3]  = mk(0, 32'h0,   0, 1, 4'h3, 32'hDEADBEEF, 32'h2004, 0, 32'h0, 0, 0, 0, 1, 32'h2004, 4'h3, 32'hDEADBEEF);
        vecs[4]  = mk(0, 32'h0,   0, 1, 4'h3, 32'hDEADBEEF, 32'h2004, 0, 32'h0, 0, 0, 0, 1, 32'h2004, 4'h3, 32'hDEADBEEF);
        vecs[5]  = mk(0, 32'h0,   0, 1, 4'h3, 32'hDEADBEEF, 32'h2004, 1, 32'h0, 0, 1, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[6]  = mk(0, 32'h0,   0, 0, 4'h0, 32'h0, 32'h0,    0, 32'h0,  0, 0, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[7]  = mk(1, 32'h300, 1, 0, 4'h0, 32'h0, 32'h400,  0, 32'h0,  0, 0, 1, 0, 32'h400,  4'h0, 32'h0);
        vecs[8]  = mk(1, 32'h300, 1, 0, 4'h0, 32'h0, 32'h400,  1, 32'hAA, 0, 1, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[9]  = mk(1, 32'h300, 1, 0, 4'h0, 32'h0, 32'h400,  0, 32'h0,  0, 0, 1, 0, 32'h400,  4'h0, 32'h0);
        vecs[10] = mk(1, 32'h300, 1, 0, 4'h0, 32'h0, 32'h400,  1, 32'hAB, 0, 1, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[11] = mk(1, 32'h300, 1, 0, 4'h0, 32'h0, 32'h400,  0, 32'h0,  0, 0, 1, 0, 32'h400,  4'h0, 32'h0);
        vecs[12] = mk(1, 32'h300, 1, 0, 4'h0, 32'h0, 32'h400,  1, 32'hAC, 0, 1, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[13] = mk(1, 32'h300, 0, 0, 4'h0, 32'h0, 32'h0,    0, 32'h0,  0, 0, 1, 0, 32'h300,  4'h0, 32'h0);
        vecs[14] = mk(1, 32'h300, 0, 0, 4'h0, 32'h0, 32'h0,    1, 32'h55, 1, 0, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[15] = mk(0, 32'h0,   0, 0, 4'h0, 32'h0, 32'h0,    0, 32'h0,  0, 0, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[16] = mk(0, 32'h0,   1, 1, 4'hF, 32'h12345678, 32'h500, 0, 32'h0, 0, 0, 0, 1, 32'h500, 4'hF, 32'h12345678);
        vecs[17] = mk(0, 32'h0,   1, 1, 4'hF, 32'h12345678, 32'h500, 1, 32'h9, 0, 1, 0, 0, 32'h0,  4'h0, 32'h0);
        vecs[18] = mk(0, 32'h0,   0, 0, 4'h0, 32'h0, 32'h0,    1, 32'h7,  0, 0, 0, 0, 32'h0,    4'h0, 32'h0);

        reset = 1'b1;
        instr_read_in = 0; instr_address_in = 0; data_read_in = 0; data_write_in = 0;
        data_write_mask_in = 0; data_write_value_in = 0; data_address_in = 0;
        mem_ready_in = 0; mem_read_value_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_bus_zero("reset");
        chk("reset instr_ready", p_ir, 0);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Flush: instr dropped after grant, re-requested at 0x200 while the slave is busy.
        seq.delete();
        seq.push_back(mk(1, 32'h180, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, 32'h180, 0, 0));
        seq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, 32'h180, 0, 0));
        seq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, 32'h180, 0, 0));
        seq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 32'h0,   0, 0));
        seq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, 32'h200, 0, 0));
        seq.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h78, 1, 0, 0, 0, 32'h0,   0, 0));
        seq.push_back(mk(0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 32'h0,   0, 0));
        foreach (seq[i]) step(seq[i], 1'b0, $sformatf("flush%0d", i));

        // Reset in the middle of a pending data read.
        step(mk(0, 32'h0, 1, 0, 0, 0, 32'h600, 0, 32'h0, 0, 0, 1, 0, 32'h600, 0, 0), 1'b0, "rst_grant");
        reset = 1'b1;
        mem_ready_in = 1'b1;
        #1;
        chk("rst_mid mem_read", p_mrd, 0);
        chk("rst_mid mem_addr", p_addr, 0);
        chk("rst_mid data_ready", p_dr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(mk(0, 32'h0,   0, 0, 0, 0, 0, 1, 32'h5, 0, 0, 0, 0, 32'h0,   0, 0), 1'b0, "rst_late");
        step(mk(1, 32'h700, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h700, 0, 0), 1'b0, "rst_new");
        step(mk(1, 32'h700, 0, 0, 0, 0, 0, 1, 32'h6, 1, 0, 0, 0, 32'h0,   0, 0), 1'b0, "rst_done");

        // Round-robin: continuous ties alternate I,D,I,D starting with instr after reset.
        reset = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "rr_reset");
        reset = 1'b0;
        seq.delete();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = (k % 2 == 0) ? 32'h800 : 32'h900;
            seq.push_back(mk(1, 32'h800, 1, 0, 0, 0, 32'h900, 0, 32'h0, 0, 0, 1, 0, a, 0, 0));
            seq.push_back(mk(1, 32'h800, 1, 0, 0, 0, 32'h900, 1, 32'h11 + k,
                             (k % 2 == 0), (k % 2 == 1), 0, 0, 32'h0, 0, 0));
        end
        foreach (seq[i]) step(seq[i], 1'b1, $sformatf("rr%0d", i));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
